alu_result_stage: RTL
=====================

// Module: alu_result_stage
// PURPOSE
//  Pipeline stage directly downstream of the 19-bit ALU: registers Result and Z/O/N flags
//  with a valid/ready handshake so back-pressure from writeback never stalls ALU timing.
//  Sanitises DIV/MOD by zero and illegal opcodes. Keeps a committed-status register.
// PARAMETERS
//  N     19  datapath width (matches ALU)
//  RDW   4   destination-register index width
// PORTS
//  clk          in   1    system clock, rising edge
//  rst_n        in   1    asynchronous active-low reset
//  in_valid     in   1    ALU output valid
//  in_ready     out  1    stage can accept
//  in_op        in   3    ALUControl of the op producing in_result
//  in_b         in   N    ALU operand B (divisor check)
//  in_result    in   N    ALU Result
//  in_zero      in   1    ALU Zero
//  in_ovf       in   1    ALU OverFlow
//  in_neg       in   1    ALU Negative
//  in_rd        in   RDW  destination register tag, passed through
//  out_valid    out  1    output valid
//  out_ready    in   1    writeback accepts
//  out_result   out  N    registered (possibly sanitised) result
//  out_zero     out  1    flag
//  out_ovf      out  1    flag
//  out_neg      out  1    flag
//  out_rd       out  RDW  tag
//  out_dbz      out  1    DIV/MOD with B==0
//  out_illegal  out  1    opcode 3'b110/3'b111
//  status       out  3    {neg,ovf,zero} of last committed op
//  sticky_clr   in   1    clear sticky_ovf (macro only)
//  sticky_ovf   out  1    OR of committed ovf since clear (macro only)
// BEHAVIOUR
//  Reset: all outputs 0 and in_ready 0 while rst_n low; in_ready 1 in the first cycle after release; both entries empty.
//  Transfer in = in_valid&in_ready; commit = out_valid&out_ready. Latency 1 cycle (in -> out_valid).
//  2-entry skid buffer: main + skid register; in_ready = !skid_full (registered, no comb path
//  from out_ready). Throughput 1/cycle with out_ready held high. out_* stable while out_valid&!out_ready.
//  Full (both entries) -> in_ready=0. Commit with skid_full -> skid moves to main, in_ready=1 next cycle.
//  Simultaneous transfer-in and commit with main-only -> new data into main, no skid use.
//  Sanitise at capture: op 3'b011/3'b100 and in_b==0 -> result={N{1}}, zero=0, ovf=1, neg=1, dbz=1.
//  op 3'b110/3'b111 -> result=0, zero=1, ovf=0, neg=0, illegal=1. Otherwise pass through, dbz=illegal=0.
//  status updates only on commit; holds otherwise. Reset mid-op discards both entries.
// CONFIGURATION
//  ALU_STICKY_OVF_EN defined: sticky_ovf <= (sticky_ovf & !sticky_clr) | (commit & out_ovf);
//   set and clear in same cycle -> set wins (1).
//  Undefined: sticky_ovf tied 0, sticky_clr ignored, no sticky flop.
// STRUCTURE
//  alu_pkg: localparam N=19; enum alu_op_e {ALU_SUM=0,ALU_RES,ALU_MULT,ALU_DIV,ALU_MOD,ALU_CLI};
//   struct alu_flags_t {neg,ovf,zero}; struct alu_res_t {result,flags,rd,dbz,illegal}.
//  Sub-module alu_skid_buf #(type T) generic 2-entry valid/ready skid; sanitise logic lives in top.
// TESTING
//  Stream SUM 5+3 (8) with out_ready=1 -> out_result=8 one cycle later, throughput 1/cycle, status=3'b000.
//  Hold out_ready=0, push 3 ops -> 2 accepted, in_ready=0; release -> ops out in order, none lost/duplicated.
//  DIV op, in_b=0 -> out_result=19'h7FFFF, out_dbz=1, out_ovf=1, out_neg=1, out_zero=0.
//  in_op=3'b111 -> out_result=0, out_illegal=1, out_zero=1; status updates only at commit.
//  With macro: commit ovf=1 while sticky_clr=1 -> sticky_ovf=1; next clr alone -> 0.
//  Assert rst_n low with both entries full -> out_valid=0 immediately, in_ready=1 one cycle after release.

Source files
------------

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
//  Shared types and constants for the ALU result stage.
//  Contents:
//   N, RDW        datapath width and destination-register tag width
//   alu_op_e      ALUControl encodings
//   alu_flags_t   {neg, ovf, zero} flag bundle (same bit order as status)
//   alu_res_t     one entry of the result stage (result, flags, tag, dbz, illegal)
//   is_div_op()   true for operations that divide by operand B
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

package alu_pkg;

   localparam int N   = 19;
   localparam int RDW = 4;

   typedef enum logic [2:0] {
      ALU_SUM  = 3'd0,
      ALU_RES  = 3'd1,
      ALU_MULT = 3'd2,
      ALU_DIV  = 3'd3,
      ALU_MOD  = 3'd4,
      ALU_CLI  = 3'd5
   } alu_op_e;

   typedef struct packed {
      logic neg;
      logic ovf;
      logic zero;
   } alu_flags_t;

   typedef struct packed {
      logic [N-1:0]   result;
      alu_flags_t     flags;
      logic [RDW-1:0] rd;
      logic           dbz;
      logic           illegal;
   } alu_res_t;

   function automatic logic is_div_op(input logic [2:0] op);
      return (op == ALU_DIV) || (op == ALU_MOD);
   endfunction

endpackage

// File: rtl/alu_skid_buf.sv
// ---------------------------------------------------------------------------
// alu_skid_buf
//  Generic 2-entry valid/ready skid buffer. Data lands in the main register
//  (which drives the outputs); when main is stalled an arriving word is parked
//  in the skid register. in_ready is registered, so there is no combinational
//  path from out_ready back to in_ready.
//  Parameters:
//   T          payload type
//  Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset, empties both entries
//   in_valid   upstream word valid
//   in_ready   buffer can accept (registered, = skid entry empty)
//   in_data    upstream payload
//   out_valid  main entry holds a word
//   out_ready  downstream accepts
//   out_data   main entry payload (held stable while stalled)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module alu_skid_buf #(
   parameter type T = logic [7:0]
) (
   input  logic clk,
   input  logic rst_n,
   input  logic in_valid,
   output logic in_ready,
   input  T     in_data,
   output logic out_valid,
   input  logic out_ready,
   output T     out_data
);

   logic main_valid_q, main_valid_d;
   logic skid_valid_q, skid_valid_d;
   logic ready_q, ready_d;
   T     main_data_q, main_data_d;
   T     skid_data_q, skid_data_d;

   logic push;
   logic pop;

   assign push = in_valid & ready_q;
   assign pop  = main_valid_q & out_ready;

   // A push can only happen while skid is empty, so when draining a full
   // buffer the skid word simply moves to main and nothing new arrives.
   always_comb begin
      main_valid_d = main_valid_q;
      main_data_d  = main_data_q;
      skid_valid_d = skid_valid_q;
      skid_data_d  = skid_data_q;
      if (pop) begin
         if (skid_valid_q) begin
            main_data_d  = skid_data_q;
            skid_valid_d = 1'b0;
         end else begin
            main_valid_d = push;
            if (push) begin
               main_data_d = in_data;
            end
         end
      end else if (push) begin
         if (main_valid_q) begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_data;
         end else begin
            main_valid_d = 1'b1;
            main_data_d  = in_data;
         end
      end
      ready_d = ~skid_valid_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_valid_q <= 1'b0;
         skid_valid_q <= 1'b0;
         ready_q      <= 1'b0;
         main_data_q  <= '0;
         skid_data_q  <= '0;
      end else begin
         main_valid_q <= main_valid_d;
         skid_valid_q <= skid_valid_d;
         ready_q      <= ready_d;
         main_data_q  <= main_data_d;
         skid_data_q  <= skid_data_d;
      end
   end

   assign in_ready  = ready_q;
   assign out_valid = main_valid_q;
   assign out_data  = main_data_q;

endmodule

// File: rtl/alu_result_stage.sv
// ---------------------------------------------------------------------------
// alu_result_stage
//  Registers the ALU result and Z/O/N flags behind a 2-entry skid buffer so
//  writeback back-pressure never reaches ALU timing. DIV/MOD by zero and
//  illegal opcodes are sanitised on capture. status holds {neg,ovf,zero} of
//  the last committed op.
//  Configuration macro:
//   ALU_STICKY_OVF_EN  adds sticky_ovf (OR of committed ovf since sticky_clr);
//                      when undefined sticky_ovf is 0 and sticky_clr is ignored.
//  Ports:
//   clk, rst_n                         clock, async active-low reset
//   in_valid/in_ready                  ALU side handshake
//   in_op, in_b                        opcode and divisor for sanitising
//   in_result, in_zero/ovf/neg, in_rd  ALU result, flags, destination tag
//   out_valid/out_ready                writeback side handshake
//   out_result, out_zero/ovf/neg       registered result and flags
//   out_rd, out_dbz, out_illegal       tag, divide-by-zero and illegal-op marks
//   status                             {neg,ovf,zero} of last commit
//   sticky_clr, sticky_ovf             sticky overflow control/status
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module alu_result_stage
   import alu_pkg::*;
(
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [2:0]     in_op,
   input  logic [N-1:0]   in_b,
   input  logic [N-1:0]   in_result,
   input  logic           in_zero,
   input  logic           in_ovf,
   input  logic           in_neg,
   input  logic [RDW-1:0] in_rd,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [N-1:0]   out_result,
   output logic           out_zero,
   output logic           out_ovf,
   output logic           out_neg,
   output logic [RDW-1:0] out_rd,
   output logic           out_dbz,
   output logic           out_illegal,
   output logic [2:0]     status,
   input  logic           sticky_clr,
   output logic           sticky_ovf
);

   alu_res_t   cap;
   alu_res_t   res;
   alu_flags_t status_q, status_d;
   logic       commit;

   // Illegal opcodes take priority; they never divide, so the two cases
   // cannot overlap anyway.
   always_comb begin
      cap         = '0;
      cap.rd      = in_rd;
      if (in_op[2:1] == 2'b11) begin
         cap.result     = '0;
         cap.flags.zero = 1'b1;
         cap.illegal    = 1'b1;
      end else if (is_div_op(in_op) && (in_b == '0)) begin
         cap.result     = '1;
         cap.flags.neg  = 1'b1;
         cap.flags.ovf  = 1'b1;
         cap.dbz        = 1'b1;
      end else begin
         cap.result     = in_result;
         cap.flags.neg  = in_neg;
         cap.flags.ovf  = in_ovf;
         cap.flags.zero = in_zero;
      end
   end

   alu_skid_buf #(
      .T (alu_res_t)
   ) u_skid (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (cap),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (res)
   );

   assign commit = out_valid & out_ready;

   always_comb begin
      status_d = status_q;
      if (commit) begin
         status_d = res.flags;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         status_q <= '0;
      end else begin
         status_q <= status_d;
      end
   end

`ifdef ALU_STICKY_OVF_EN
   logic sticky_ovf_q, sticky_ovf_d;

   // Set wins over clear when both happen in the same cycle.
   always_comb begin
      sticky_ovf_d = (sticky_ovf_q & ~sticky_clr) | (commit & res.flags.ovf);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sticky_ovf_q <= 1'b0;
      end else begin
         sticky_ovf_q <= sticky_ovf_d;
      end
   end

   assign sticky_ovf = sticky_ovf_q;
`else
   logic unused_sticky_clr;
   assign unused_sticky_clr = sticky_clr;
   assign sticky_ovf        = 1'b0;
`endif

   assign out_result  = res.result;
   assign out_zero    = res.flags.zero;
   assign out_ovf     = res.flags.ovf;
   assign out_neg     = res.flags.neg;
   assign out_rd      = res.rd;
   assign out_dbz     = res.dbz;
   assign out_illegal = res.illegal;
   assign status      = status_q;

endmodule
